// File: rtl/sdram_wr_burst.sv
// Write-data beat sequencer: prefetches 32-bit words from the word FIFO and
// streams them as 16-bit SDRAM beats, masking beats when the FIFO runs dry.
module sdram_wr_burst #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_rdata,
  output logic        fifo_read_enable,
  input  logic        wr_start,
  output logic        wr_ready,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [1:0]  dqm,
  output logic        burst_done,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE, FETCH, LOADED, BURST} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [2:0]  beat_q, beat_d;
  logic        word_valid_q, word_valid_d;
  logic        popped_q, popped_d;

  logic last_beat;
  logic refill_beat;
  logic reload_beat;

  // Refill pops on the low beat of a word that has a successor; the popped
  // word lands in hold at the end of the following high beat.
  assign last_beat   = (beat_q == 3'(BURST_LEN - 1));
  assign refill_beat = !beat_q[0] && (({1'b0, beat_q} + 4'd2) < 4'(BURST_LEN));
  assign reload_beat = beat_q[0] && (({1'b0, beat_q} + 4'd1) < 4'(BURST_LEN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      beat_q       <= '0;
      word_valid_q <= 1'b0;
      popped_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      beat_q       <= beat_d;
      word_valid_q <= word_valid_d;
      popped_q     <= popped_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    beat_d       = beat_q;
    word_valid_d = word_valid_q;
    popped_d     = popped_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        hold_d       = fifo_rdata;
        word_valid_d = 1'b1;
        state_d      = LOADED;
      end
      LOADED: begin
        if (wr_start) begin
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        beat_d = beat_q + 3'd1;
        if (refill_beat) popped_d = !fifo_empty;
        if (reload_beat) begin
          if (popped_q) hold_d = fifo_rdata;
          word_valid_d = popped_q;
        end
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, whatever state is stored.
  always_comb begin
    fifo_read_enable = 1'b0;
    wr_ready         = 1'b0;
    dq_out           = '0;
    dq_oe            = 1'b0;
    dqm              = 2'b00;
    burst_done       = 1'b0;
    underrun         = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:   fifo_read_enable = !fifo_empty;
        LOADED: wr_ready = 1'b1;
        BURST: begin
          dq_oe            = 1'b1;
          fifo_read_enable = refill_beat && !fifo_empty;
          burst_done       = last_beat;
          underrun         = !word_valid_q && !beat_q[0];
          if (word_valid_q) begin
            dq_out = beat_q[0] ? hold_q[31:16] : hold_q[15:0];
          end else begin
            dqm = 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
